// File: rtl/tec_lock_monitor_pkg.sv
// Shared state codes and the temperature window compare used by every
// TEC lock-monitor channel.
package tec_mon_pkg;

    typedef enum logic [7:0] {
        ST_IDLE    = 8'h00,
        ST_COOLING = 8'h01,
        ST_LOCKED  = 8'h02,
        ST_FAULT   = 8'h03
    } state_e;

    localparam int WIN_W = 32;

    // Magnitude is taken as larger-minus-smaller, so it can never wrap;
    // this matches a one-bit-wider signed difference followed by abs().
    function automatic logic in_window(
        input logic [WIN_W-1:0] temp,
        input logic [WIN_W-1:0] target,
        input logic [WIN_W-1:0] tol
    );
        logic [WIN_W-1:0] diff;
        if (temp >= target) begin
            diff = temp - target;
        end else begin
            diff = target - temp;
        end
        return diff <= tol;
    endfunction

endpackage

// File: rtl/tec_lock_monitor_if.sv
// Host-side control/sample bus and status outputs of the TEC lock monitor.
// The master drives enables, targets and samples; the slave reports status.
interface tec_lock_monitor_if #(
    parameter int CH   = 4,
    parameter int TW   = 16,
    parameter int TO_W = 32
);

    logic [CH-1:0]    cooling_en;
    logic [CH*TW-1:0] target_temp;
    logic [CH-1:0]    temp_valid;
    logic [CH*TW-1:0] temp;
    logic [TW-1:0]    tolerance;
    logic [TO_W-1:0]  timeout_limit;
    logic [CH-1:0]    fault_clr;

    logic [CH*8-1:0]  cooling_state;
    logic [CH-1:0]    locked;
    logic             all_locked;
    logic [CH-1:0]    fault;
    logic [CH-1:0]    state_chg;

    modport master (
        output cooling_en,
        output target_temp,
        output temp_valid,
        output temp,
        output tolerance,
        output timeout_limit,
        output fault_clr,
        input  cooling_state,
        input  locked,
        input  all_locked,
        input  fault,
        input  state_chg
    );

    modport slave (
        input  cooling_en,
        input  target_temp,
        input  temp_valid,
        input  temp,
        input  tolerance,
        input  timeout_limit,
        input  fault_clr,
        output cooling_state,
        output locked,
        output all_locked,
        output fault,
        output state_chg
    );

endinterface

// File: rtl/tec_lock_channel.sv
// One TEC channel: window compare, lock/unlock hysteresis counters,
// COOLING stall timeout and the sticky fault state.
module tec_lock_channel
    import tec_mon_pkg::*;
#(
    parameter int TW       = 16,
    parameter int LOCK_CNT = 8,
    parameter int UNLK_CNT = 4,
    parameter int TO_W     = 32
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            en,
    input  logic            valid,
    input  logic            fault_clr,
    input  logic [TW-1:0]   target,
    input  logic [TW-1:0]   temp,
    input  logic [TW-1:0]   tol,
    input  logic [TO_W-1:0] limit,
    output logic [7:0]      state_code,
    output logic            locked,
    output logic            fault,
    output logic            state_chg,
    output logic            lock_nxt
);

    localparam int IW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLK_CNT + 1);
    localparam logic [IW-1:0] IN_LAST  = IW'(LOCK_CNT - 1);
    localparam logic [UW-1:0] OUT_LAST = UW'(UNLK_CNT - 1);

    state_e          st;
    state_e          st_n;
    logic [IW-1:0]   in_cnt;
    logic [IW-1:0]   in_n;
    logic [UW-1:0]   out_cnt;
    logic [UW-1:0]   out_n;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_n;
    logic            hit;
    logic            to_hit;
    logic            clr;

    always_comb begin
        st_n   = st;
        in_n   = in_cnt;
        out_n  = out_cnt;
        to_n   = to_cnt;
        clr    = 1'b0;
        hit    = in_window(WIN_W'(temp), WIN_W'(target), WIN_W'(tol));
        to_hit = (limit != '0) && (to_cnt == limit - TO_W'(1));

        if (!en) begin
            st_n = ST_IDLE;
            clr  = 1'b1;
        end else begin
            unique case (st)
                ST_IDLE: begin
                    st_n = ST_COOLING;
                    clr  = 1'b1;
                end
                ST_COOLING: begin
                    // A completing lock sample beats a same-cycle timeout.
                    if (valid && hit && in_cnt >= IN_LAST) begin
                        st_n = ST_LOCKED;
                        clr  = 1'b1;
                    end else if (to_hit) begin
                        st_n = ST_FAULT;
                        clr  = 1'b1;
                    end else begin
                        if (to_cnt != '1) begin
                            to_n = to_cnt + TO_W'(1);
                        end
                        if (valid) begin
                            in_n = hit ? in_cnt + IW'(1) : '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (valid) begin
                        if (hit) begin
                            out_n = '0;
                        end else if (out_cnt >= OUT_LAST) begin
                            st_n = ST_COOLING;
                            clr  = 1'b1;
                        end else begin
                            out_n = out_cnt + UW'(1);
                        end
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        st_n = ST_COOLING;
                        clr  = 1'b1;
                    end
                end
                default: begin
                    st_n = ST_IDLE;
                    clr  = 1'b1;
                end
            endcase
        end

        if (clr) begin
            in_n  = '0;
            out_n = '0;
            to_n  = '0;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            st        <= ST_IDLE;
            in_cnt    <= '0;
            out_cnt   <= '0;
            to_cnt    <= '0;
            locked    <= 1'b0;
            fault     <= 1'b0;
            state_chg <= 1'b0;
        end else begin
            st        <= st_n;
            in_cnt    <= in_n;
            out_cnt   <= out_n;
            to_cnt    <= to_n;
            locked    <= (st_n == ST_LOCKED);
            fault     <= (st_n == ST_FAULT);
            state_chg <= (st_n != st);
        end
    end

    assign state_code = st;
    assign lock_nxt   = (st_n == ST_LOCKED);

endmodule

// File: rtl/tec_lock_monitor.sv
// Multi-channel TEC lock monitor: CH independent channel FSMs plus the
// registered all-enabled-channels-locked summary.
module tec_lock_monitor #(
    parameter int CH       = 4,
    parameter int TW       = 16,
    parameter int LOCK_CNT = 8,
    parameter int UNLK_CNT = 4,
    parameter int TO_W     = 32
) (
    input logic               CLK,
    input logic               rst_n,
    tec_lock_monitor_if.slave bus
);

    logic [CH*8-1:0] state_bus;
    logic [CH-1:0]   locked_bus;
    logic [CH-1:0]   fault_bus;
    logic [CH-1:0]   chg_bus;
    logic [CH-1:0]   lock_nxt;
    logic            all_q;

    for (genvar k = 0; k < CH; k++) begin : g_ch
        tec_lock_channel #(
            .TW       (TW),
            .LOCK_CNT (LOCK_CNT),
            .UNLK_CNT (UNLK_CNT),
            .TO_W     (TO_W)
        ) u_ch (
            .CLK        (CLK),
            .rst_n      (rst_n),
            .en         (bus.cooling_en[k]),
            .valid      (bus.temp_valid[k]),
            .fault_clr  (bus.fault_clr[k]),
            .target     (bus.target_temp[k*TW +: TW]),
            .temp       (bus.temp[k*TW +: TW]),
            .tol        (bus.tolerance),
            .limit      (bus.timeout_limit),
            .state_code (state_bus[k*8 +: 8]),
            .locked     (locked_bus[k]),
            .fault      (fault_bus[k]),
            .state_chg  (chg_bus[k]),
            .lock_nxt   (lock_nxt[k])
        );
    end

    // Built from next-state lock so it lines up with the registered locked bits.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            all_q <= 1'b0;
        end else begin
            all_q <= (|bus.cooling_en) & (&(lock_nxt | ~bus.cooling_en));
        end
    end

    assign bus.cooling_state = state_bus;
    assign bus.locked        = locked_bus;
    assign bus.fault         = fault_bus;
    assign bus.state_chg     = chg_bus;
    assign bus.all_locked    = all_q;

endmodule

// File: tb/tb_tec_lock_monitor.sv
// Directed and randomized bench for tec_lock_monitor against a
// cycle-level behavioural model of each channel.
module tb_tec_lock_monitor;

    localparam int CH       = 4;
    localparam int TW       = 16;
    localparam int LOCK_CNT = 8;
    localparam int UNLK_CNT = 4;
    localparam int TO_W     = 32;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    always #25 CLK = ~CLK;

    tec_lock_monitor_if #(.CH(CH), .TW(TW), .TO_W(TO_W)) bus ();

    tec_lock_monitor #(
        .CH       (CH),
        .TW       (TW),
        .LOCK_CNT (LOCK_CNT),
        .UNLK_CNT (UNLK_CNT),
        .TO_W     (TO_W)
    ) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // model: mode 0 idle, 1 cooling, 2 locked, 3 fault
    int      m_mode [CH];
    int      m_in   [CH];
    int      m_out  [CH];
    longint  m_t    [CH];
    logic [CH-1:0] m_chg;
    logic    m_all;

    function automatic logic [7:0] st_of(int k);
        return bus.cooling_state[k*8 +: 8];
    endfunction

    task automatic set_temp(int k, logic [15:0] v);
        bus.temp[k*TW +: TW] = v;
    endtask

    task automatic set_tgt(int k, logic [15:0] v);
        bus.target_temp[k*TW +: TW] = v;
    endtask

    task automatic tick();
        int nm [CH];
        int ni [CH];
        int no [CH];
        longint nt [CH];
        logic anyen;
        logic alll;
        longint lim;
        lim = longint'(bus.timeout_limit);
        for (int k = 0; k < CH; k++) begin
            int t;
            int tg;
            int d;
            logic v;
            logic good;
            logic bad;
            t    = int'(bus.temp[k*TW +: TW]);
            tg   = int'(bus.target_temp[k*TW +: TW]);
            d    = t - tg;
            if (d < 0) d = -d;
            v    = bus.temp_valid[k];
            good = v && (d <= int'(bus.tolerance));
            bad  = v && !good;
            nm[k] = m_mode[k];
            ni[k] = m_in[k];
            no[k] = m_out[k];
            nt[k] = m_t[k];
            if (!bus.cooling_en[k]) begin
                nm[k] = 0; ni[k] = 0; no[k] = 0; nt[k] = 0;
            end else begin
                case (m_mode[k])
                    0: begin
                        nm[k] = 1; ni[k] = 0; no[k] = 0; nt[k] = 0;
                    end
                    1: begin
                        if (good && m_in[k] + 1 >= LOCK_CNT) begin
                            nm[k] = 2; ni[k] = 0; no[k] = 0; nt[k] = 0;
                        end else if (lim != 0 && m_t[k] + 1 == lim) begin
                            nm[k] = 3; ni[k] = 0; no[k] = 0; nt[k] = 0;
                        end else begin
                            nt[k] = m_t[k] + 1;
                            if (v) ni[k] = good ? m_in[k] + 1 : 0;
                        end
                    end
                    2: begin
                        if (bad) begin
                            if (m_out[k] + 1 >= UNLK_CNT) begin
                                nm[k] = 1; ni[k] = 0; no[k] = 0; nt[k] = 0;
                            end else begin
                                no[k] = m_out[k] + 1;
                            end
                        end else if (v) begin
                            no[k] = 0;
                        end
                    end
                    3: begin
                        if (bus.fault_clr[k]) begin
                            nm[k] = 1; ni[k] = 0; no[k] = 0; nt[k] = 0;
                        end
                    end
                    default: nm[k] = 0;
                endcase
            end
            if (!rst_n) begin
                nm[k] = 0; ni[k] = 0; no[k] = 0; nt[k] = 0;
            end
        end
        anyen = (|bus.cooling_en) && rst_n;
        alll  = 1'b1;
        for (int k = 0; k < CH; k++) begin
            if (bus.cooling_en[k] && nm[k] != 2) alll = 1'b0;
        end
        @(posedge CLK);
        for (int k = 0; k < CH; k++) begin
            m_chg[k]  = rst_n && (nm[k] != m_mode[k]);
            m_mode[k] = nm[k];
            m_in[k]   = ni[k];
            m_out[k]  = no[k];
            m_t[k]    = nt[k];
        end
        m_all = anyen & alll;
        #1;
        bus.temp_valid = '0;
        bus.fault_clr  = '0;
    endtask

    task automatic feed_good(logic [CH-1:0] mask, int n);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < CH; k++) begin
                if (mask[k]) set_temp(k, bus.target_temp[k*TW +: TW]);
            end
            bus.temp_valid = mask;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if (bus.cooling_state !== '0) begin
            errors++;
            $display("FAIL rst_state got=%0h exp=0", bus.cooling_state);
        end
        checks++;
        if (bus.locked !== '0 || bus.fault !== '0) begin
            errors++;
            $display("FAIL rst_lock_fault got=%0h/%0h exp=0/0", bus.locked, bus.fault);
        end
        checks++;
        if (bus.all_locked !== 1'b0 || bus.state_chg !== '0) begin
            errors++;
            $display("FAIL rst_all_chg got=%0b/%0h exp=0/0", bus.all_locked, bus.state_chg);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.state_chg !== '0 || bus.cooling_state !== '0) begin
            errors++;
            $display("FAIL rst_release got=%0h/%0h exp=0/0", bus.state_chg, bus.cooling_state);
        end
    endtask

    task automatic test_lock();
        bus.cooling_en[0] = 1'b1;
        tick();
        checks++;
        if (st_of(0) !== 8'h01 || bus.state_chg[0] !== 1'b1) begin
            errors++;
            $display("FAIL lock_enter got=%0h/%0b exp=1/1", st_of(0), bus.state_chg[0]);
        end
        tick();
        checks++;
        if (bus.state_chg[0] !== 1'b0) begin
            errors++;
            $display("FAIL lock_chg_pulse got=%0b exp=0", bus.state_chg[0]);
        end
        for (int i = 0; i < 8; i++) begin
            set_temp(0, 16'h0102);
            bus.temp_valid[0] = 1'b1;
            tick();
            checks++;
            if (st_of(0) !== ((i < 7) ? 8'h01 : 8'h02) || bus.state_chg[0] !== (i == 7)) begin
                errors++;
                $display("FAIL lock_seq i=%0d got=%0h/%0b exp=%0h/%0b", i, st_of(0),
                         bus.state_chg[0], (i < 7) ? 1 : 2, (i == 7));
            end
        end
        checks++;
        if (bus.locked[0] !== 1'b1) begin
            errors++;
            $display("FAIL lock_flag got=%0b exp=1", bus.locked[0]);
        end
    endtask

    task automatic test_hysteresis();
        logic [15:0] seq [8];
        logic [7:0]  exp [8];
        seq = '{16'h0110, 16'h0110, 16'h0110, 16'h0100,
                16'h0110, 16'h0110, 16'h0110, 16'h0110};
        exp = '{8'h2, 8'h2, 8'h2, 8'h2, 8'h2, 8'h2, 8'h2, 8'h1};
        for (int i = 0; i < 8; i++) begin
            set_temp(0, seq[i]);
            bus.temp_valid[0] = 1'b1;
            tick();
            checks++;
            if (st_of(0) !== exp[i] || bus.locked[0] !== (exp[i] == 8'h2)) begin
                errors++;
                $display("FAIL hyst i=%0d got=%0h exp=%0h", i, st_of(0), exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_locked();
        feed_good(4'b0001, 8);
        checks++;
        if (bus.locked[0] !== 1'b1 || bus.all_locked !== 1'b1) begin
            errors++;
            $display("FAIL rstl_pre got=%0b/%0b exp=1/1", bus.locked[0], bus.all_locked);
        end
        #10;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.cooling_state !== '0 || bus.locked !== '0 || bus.all_locked !== 1'b0 ||
            bus.fault !== '0 || bus.state_chg !== '0) begin
            errors++;
            $display("FAIL rstl_async got=%0h/%0h/%0b exp=0/0/0", bus.cooling_state,
                     bus.locked, bus.all_locked);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (st_of(0) !== 8'h00) begin
            errors++;
            $display("FAIL rstl_idle got=%0h exp=0", st_of(0));
        end
        tick();
        checks++;
        if (st_of(0) !== 8'h01 || bus.state_chg[0] !== 1'b1) begin
            errors++;
            $display("FAIL rstl_restart got=%0h/%0b exp=1/1", st_of(0), bus.state_chg[0]);
        end
    endtask

    task automatic test_timeout();
        bus.cooling_en[0] = 1'b0;
        tick();
        bus.timeout_limit = 100;
        bus.cooling_en[0] = 1'b1;
        tick();
        for (int n = 1; n <= 100; n++) begin
            if (n % 3 == 0) begin
                set_temp(0, 16'h0200);
                bus.temp_valid[0] = 1'b1;
            end
            tick();
            if (n == 99) begin
                checks++;
                if (st_of(0) !== 8'h01) begin
                    errors++;
                    $display("FAIL to_99 got=%0h exp=1", st_of(0));
                end
            end
            if (n == 100) begin
                checks++;
                if (st_of(0) !== 8'h03 || bus.fault[0] !== 1'b1 || bus.state_chg[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL to_100 got=%0h/%0b exp=3/1", st_of(0), bus.fault[0]);
                end
            end
        end
        feed_good(4'b0001, 10);
        checks++;
        if (st_of(0) !== 8'h03) begin
            errors++;
            $display("FAIL to_sticky got=%0h exp=3", st_of(0));
        end
        bus.fault_clr[0] = 1'b1;
        tick();
        checks++;
        if (st_of(0) !== 8'h01 || bus.fault[0] !== 1'b0) begin
            errors++;
            $display("FAIL to_clr got=%0h/%0b exp=1/0", st_of(0), bus.fault[0]);
        end
        bus.timeout_limit = 0;
        for (int n = 0; n < 300; n++) begin
            set_temp(0, 16'h0200);
            bus.temp_valid[0] = n[0];
            tick();
        end
        checks++;
        if (st_of(0) !== 8'h01) begin
            errors++;
            $display("FAIL to_disabled got=%0h exp=1", st_of(0));
        end
    endtask

    task automatic test_priority();
        bus.cooling_en[0] = 1'b0;
        tick();
        bus.timeout_limit = 5;
        bus.cooling_en[0] = 1'b1;
        tick();
        repeat (5) tick();
        checks++;
        if (st_of(0) !== 8'h03) begin
            errors++;
            $display("FAIL pri_fault got=%0h exp=3", st_of(0));
        end
        bus.cooling_en[0] = 1'b0;
        bus.fault_clr[0]  = 1'b1;
        tick();
        checks++;
        if (st_of(0) !== 8'h00 || bus.state_chg[0] !== 1'b1) begin
            errors++;
            $display("FAIL pri_en_over_clr got=%0h/%0b exp=0/1", st_of(0), bus.state_chg[0]);
        end
        bus.timeout_limit = 8;
        bus.cooling_en[0] = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            feed_good(4'b0001, 1);
            if (i == 6) begin
                checks++;
                if (st_of(0) !== 8'h01) begin
                    errors++;
                    $display("FAIL pri_pre_lock got=%0h exp=1", st_of(0));
                end
            end
        end
        checks++;
        if (st_of(0) !== 8'h02) begin
            errors++;
            $display("FAIL pri_lock_vs_to got=%0h exp=2", st_of(0));
        end
        bus.cooling_en[0] = 1'b0;
        tick();
        bus.cooling_en[0] = 1'b1;
        tick();
        feed_good(4'b0001, 7);
        tick();
        checks++;
        if (st_of(0) !== 8'h03) begin
            errors++;
            $display("FAIL pri_to_7good got=%0h exp=3", st_of(0));
        end
        bus.cooling_en[0] = 1'b0;
        bus.timeout_limit = 0;
        tick();
    endtask

    task automatic test_wrap_all_locked();
        set_tgt(1, 16'hFFFF);
        bus.tolerance = 1;
        bus.cooling_en = 4'b0010;
        tick();
        for (int i = 0; i < 20; i++) begin
            set_temp(1, 16'h0000);
            bus.temp_valid[1] = 1'b1;
            tick();
        end
        checks++;
        if (st_of(1) !== 8'h01 || bus.locked[1] !== 1'b0) begin
            errors++;
            $display("FAIL wrap got=%0h/%0b exp=1/0", st_of(1), bus.locked[1]);
        end
        bus.tolerance = 2;
        set_tgt(2, 16'h0100);
        set_tgt(3, 16'h0100);
        bus.cooling_en = 4'b1100;
        tick();
        checks++;
        if (bus.all_locked !== 1'b0) begin
            errors++;
            $display("FAIL all_pre got=%0b exp=0", bus.all_locked);
        end
        for (int i = 0; i < 8; i++) begin
            set_temp(2, 16'h0101);
            set_temp(3, 16'h00FF);
            bus.temp_valid = 4'b1100;
            tick();
        end
        checks++;
        if (bus.locked !== 4'b1100 || bus.all_locked !== 1'b1) begin
            errors++;
            $display("FAIL all_locked got=%0h/%0b exp=c/1", bus.locked, bus.all_locked);
        end
        bus.cooling_en[1] = 1'b1;
        tick();
        checks++;
        if (bus.all_locked !== 1'b0) begin
            errors++;
            $display("FAIL all_partial got=%0b exp=0", bus.all_locked);
        end
        bus.cooling_en = '0;
        tick();
        checks++;
        if (bus.all_locked !== 1'b0 || bus.state_chg !== 4'b1110) begin
            errors++;
            $display("FAIL all_none got=%0b/%0h exp=0/e", bus.all_locked, bus.state_chg);
        end
    endtask

    task automatic test_random();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.tolerance     = 4;
        bus.timeout_limit = 60;
        bus.cooling_en    = 4'($urandom);
        for (int k = 0; k < CH; k++) set_tgt(k, 16'($urandom));
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) == 0) bus.cooling_en[$urandom_range(0, CH-1)] ^= 1'b1;
            if ($urandom_range(0, 299) == 0) bus.tolerance = 16'($urandom_range(0, 20));
            if ($urandom_range(0, 499) == 0)
                bus.timeout_limit = $urandom_range(0, 1) ? 0 : $urandom_range(30, 80);
            for (int k = 0; k < CH; k++) begin
                int tg;
                int off;
                int t;
                int tl;
                if ($urandom_range(0, 199) == 0) begin
                    case ($urandom_range(0, 2))
                        0: set_tgt(k, 16'h0000);
                        1: set_tgt(k, 16'hFFFF);
                        default: set_tgt(k, 16'($urandom));
                    endcase
                end
                tg = int'(bus.target_temp[k*TW +: TW]);
                tl = int'(bus.tolerance);
                if ($urandom_range(0, 9) < 8) off = int'($urandom_range(0, 2*tl)) - tl;
                else off = (tl + 1 + int'($urandom_range(0, 50))) * ($urandom_range(0, 1) ? 1 : -1);
                t = tg + off;
                if (t < 0) t = 0;
                if (t > 65535) t = 65535;
                set_temp(k, 16'(t));
                bus.temp_valid[k] = 1'($urandom_range(0, 1));
                bus.fault_clr[k]  = ($urandom_range(0, 15) == 0);
            end
            tick();
            for (int k = 0; k < CH; k++) begin
                checks++;
                if (st_of(k) !== 8'(m_mode[k]) || bus.state_chg[k] !== m_chg[k]) begin
                    errors++;
                    $display("FAIL rnd_state c=%0d ch=%0d got=%0h/%0b exp=%0h/%0b", c, k,
                             st_of(k), bus.state_chg[k], m_mode[k], m_chg[k]);
                end
                checks++;
                if (bus.locked[k] !== (m_mode[k] == 2) || bus.fault[k] !== (m_mode[k] == 3)) begin
                    errors++;
                    $display("FAIL rnd_flags c=%0d ch=%0d got=%0b/%0b exp=%0b/%0b", c, k,
                             bus.locked[k], bus.fault[k], (m_mode[k] == 2), (m_mode[k] == 3));
                end
            end
            checks++;
            if (bus.all_locked !== m_all) begin
                errors++;
                $display("FAIL rnd_all c=%0d got=%0b exp=%0b", c, bus.all_locked, m_all);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < CH; k++) begin
            m_mode[k] = 0; m_in[k] = 0; m_out[k] = 0; m_t[k] = 0;
        end
        m_chg = '0;
        m_all = 1'b0;
        bus.cooling_en    = '0;
        bus.temp_valid    = '0;
        bus.temp          = '0;
        bus.fault_clr     = '0;
        bus.tolerance     = 16'd2;
        bus.timeout_limit = '0;
        for (int k = 0; k < CH; k++) set_tgt(k, 16'h0100);
        test_reset();
        test_lock();
        test_hysteresis();
        test_reset_locked();
        test_timeout();
        test_priority();
        test_wrap_all_locked();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
